// File: rtl/sm_mul_seq.sv
// Iterative sign-magnitude multiplier: shift-and-add, one multiplier magnitude bit per clock.
// A W-bit by W-bit operand pair gives a (2W-1)-bit sign-magnitude product after W-1 run cycles.
module sm_mul_seq #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   num1,
    input  logic [W-1:0]   num2,
    output logic           busy,
    output logic           done,
    output logic [2*W-2:0] num1_num2
);

    localparam int MW = 2 * W - 2;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q;
    logic [MW-1:0]   mag_a_q;
    logic [W-2:0]    mag_b_q;
    logic [MW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            sgn_q;
    logic            busy_q;
    logic            done_q;
    logic [2*W-2:0]  prod_q;
    logic [MW-1:0]   acc_d;

    // Accumulator value after this cycle's conditional add; also feeds the final product.
    always_comb begin
        acc_d = acc_q + (mag_b_q[0] ? mag_a_q : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees the previous cycle's values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_a_q <= {{(W-1){1'b0}}, num1[W-2:0]};
                        mag_b_q <= num2[W-2:0];
                        sgn_q   <= num1[W-1] ^ num2[W-1];
                        acc_q   <= '0;
                        cnt_q   <= CW'(W - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    mag_a_q <= mag_a_q << 1;
                    mag_b_q <= mag_b_q >> 1;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Zero magnitude always reports a positive sign.
                        prod_q  <= {sgn_q & (|acc_d), acc_d};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign num1_num2 = prod_q;

endmodule
